// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle wide adder. Two N-bit operands (N = WIDTH*CHUNKS) are latched on
// request acceptance and summed one WIDTH-bit slice per clock with a
// ripple-carry add. The carry between slices is held in a register, so the
// result appears CHUNKS edges after the accepting edge.
//
// Optional feature macro: CHUNKED_ADDER_OVF_EN
//   When defined, adds the out_ovf port (two's-complement signed overflow of
//   the full-width add), registered alongside out_cout.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand source has a request
//   in_ready   out  block can accept a request (high in IDLE)
//   in_a/in_b  in   N-bit operands
//   in_cin     in   carry into slice 0
//   out_valid  out  result available (held in DONE)
//   out_ready  in   consumer accepts the result
//   out_sum    out  N-bit registered sum
//   out_cout   out  registered carry out of the top slice
//   busy       out  high in RUN or DONE
//   out_ovf    out  signed overflow (only with CHUNKED_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module chunked_serial_adder #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHUNKS-1:0]   in_a,
    input  logic [WIDTH*CHUNKS-1:0]   in_b,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHUNKS-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      busy
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic                      out_ovf
`endif
);

    localparam int N     = WIDTH * CHUNKS;
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [N-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               valid_q, valid_d;
`ifdef CHUNKED_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Current slice operands and the slice adder result.
    logic [WIDTH-1:0]   a_slice, b_slice, slice_sum;
    logic               slice_cout;
    logic               last_slice;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_slice = a_q[i*WIDTH +: WIDTH];
                b_slice = b_q[i*WIDTH +: WIDTH];
            end
        end
        {slice_cout, slice_sum} = {1'b0, a_slice} + {1'b0, b_slice}
                                + (WIDTH+1)'(carry_q);
        last_slice = (idx_q == IDX_W'(CHUNKS - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = valid_q;
`ifdef CHUNKED_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < CHUNKS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*WIDTH +: WIDTH] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_slice) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    valid_d = 1'b1;
`ifdef CHUNKED_ADDER_OVF_EN
                    // Carry into the top bit is recovered from the sum bit:
                    // s_msb = a_msb ^ b_msb ^ c_in_msb.
                    ovf_d   = slice_cout ^ (a_slice[WIDTH-1] ^ b_slice[WIDTH-1]
                                            ^ slice_sum[WIDTH-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            // NOTE: operand registers are reset too; it is cheap here and
            // keeps every flop in a known state straight out of reset.
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // same pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_serial_adder
//
// Self-checking bench for chunked_serial_adder (WIDTH=4, CHUNKS=4). A
// transaction-level model predicts handshake and result timing from plain
// integer arithmetic; a compare process checks it on every negedge, and the
// directed tasks pin literal expected values.
// -----------------------------------------------------------------------------
module tb_chunked_serial_adder;

    localparam int WIDTH  = 4;
    localparam int CHUNKS = 4;
    localparam int N      = WIDTH * CHUNKS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a, in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic          out_cout;
    logic          busy;
`ifdef CHUNKED_ADDER_OVF_EN
    logic          out_ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef CHUNKED_ADDER_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit signed_ovf(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input bit c);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = sa + sb + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    // ---------------- Transaction-level model ----------------
    // m_left counts remaining slice cycles; m_valid marks a pending result.
    bit          m_valid;
    int          m_left;
    logic [N:0]  m_pending;
    bit          m_pend_ovf;
    logic [N-1:0] m_sum;
    bit          m_cout;
    bit          m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_left  <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_sum   <= m_pending[N-1:0];
                m_cout  <= m_pending[N];
                m_ovf   <= m_pend_ovf;
            end
        end else if (in_valid) begin
            m_pending  <= {1'b0, in_a} + {1'b0, in_b} + (N+1)'(in_cin);
            m_pend_ovf <= signed_ovf(in_a, in_b, in_cin);
            m_left     <= CHUNKS;
            m_sum      <= '0;
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n && check_en) begin
            check("mdl in_ready",  in_ready,  (!m_valid && m_left == 0));
            check("mdl busy",      busy,      (m_valid || m_left > 0));
            check("mdl out_valid", out_valid, m_valid);
            if (m_left == 0) begin
                check("mdl out_sum",  out_sum,  m_sum);
                check("mdl out_cout", out_cout, m_cout);
`ifdef CHUNKED_ADDER_OVF_EN
                check("mdl out_ovf",  out_ovf,  m_ovf);
`endif
            end
        end
    end

    // ---------------- Directed transaction ----------------
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit cin, input int stall,
                          input logic [N-1:0] exp_sum, input bit exp_cout,
                          input bit exp_ovf, input string name);
        int edges;
        @(negedge clk);
        check({name, " ready before"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        // Scramble inputs while the operation runs; result must not change.
        in_valid = 1'b0;
        in_a     = 16'hAAAA;
        in_b     = 16'hAAAA;
        in_cin   = 1'b1;
        check({name, " ready low in RUN"}, in_ready, 1'b0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, " latency"}, edges, 4);
        check({name, " sum"}, out_sum, exp_sum);
        check({name, " cout"}, out_cout, exp_cout);
`ifdef CHUNKED_ADDER_OVF_EN
        check({name, " ovf"}, out_ovf, exp_ovf);
`else
        if (exp_ovf) begin
            // signed overflow is only observable with the optional port
        end
`endif
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;  // must not be accepted while in DONE
                @(posedge clk);
                #1;
                check({name, " held valid"}, out_valid, 1'b1);
                check({name, " held sum"}, out_sum, exp_sum);
                check({name, " held ready"}, in_ready, 1'b0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({name, " valid drop"}, out_valid, 1'b0);
        check({name, " back idle"}, in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_sum",   out_sum,   16'h0000);
        check("reset out_cout",  out_cout,  1'b0);
        check("reset in_ready",  in_ready,  1'b1);
        check("reset busy",      busy,      1'b0);
        check_en = 1'b1;

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, "ripple");
        run_op(16'h0000, 16'h0000, 1'b1, 0, 16'h0001, 1'b0, 1'b0, "cin_only");
        run_op(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0, "plain");
        run_op(16'h00F0, 16'h0010, 1'b0, 5, 16'h0100, 1'b0, 1'b0, "backpressure");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
        run_op(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1, "ovf_neg");

        // Reset in the middle of RUN discards the in-flight result.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_cin   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun rst out_sum",   out_sum,   16'h0000);
        check("midrun rst out_valid", out_valid, 1'b0);
        check("midrun rst in_ready",  in_ready,  1'b1);
        check("midrun rst busy",      busy,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0, "after_reset");

        // Streaming with in_valid held high: model checks CHUNKS+2 spacing.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'(i * 16'h0F3B + 16'h8001);
            in_b     = 16'(i * 16'h1C07 + 16'h7FF0);
            in_cin   = i[0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("final idle", in_ready, 1'b1);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle wide adder. Adds two WIDTH*CHUNKS-bit operands one WIDTH-bit slice per cycle, using a ripple-carry add of the same shape as the team's RCA.
- The carry is registered between slices.
- Sits directly upstream of result consumers and directly downstream of the operand source.
- Gives wide additions a small area footprint at the cost of CHUNKS cycles of latency.
- Valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 4, bits per slice (one ripple-carry add per cycle)
- CHUNKS, 4, number of slices; total operand width N = WIDTH*CHUNKS (default 16)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand source has a valid request
- in_ready  out  1  block can accept a request
- in_a  in  N  operand A
- in_b  in  N  operand B
- in_cin  in  1  carry into slice 0
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  N  sum, registered
- out_cout  out  1  carry out of the top slice, registered
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, chunk index=0, carry reg=0
  - out_sum=0, out_cout=0, out_valid=0, busy=0
  - in_ready=1 once rst_n is high
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_a, in_b; carry reg<=in_cin; idx<=0; out_sum<=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge computes {c, s} = A[idx] + B[idx] + carry as a WIDTH+1-bit add.
  - Writes out_sum[idx*WIDTH +: WIDTH]<=s; carry<=c; idx<=idx+1.
  - On the edge where idx==CHUNKS-1: out_cout<=c, out_valid<=1, go to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout are held stable.
  - Edge with out_ready=1: out_valid<=0, go to IDLE.
  - out_ready=0: remain in DONE indefinitely (backpressure).
- Latency: out_valid rises exactly CHUNKS edges after the accepting edge.
- Throughput, with out_ready tied high: one request per CHUNKS+2 cycles (includes one IDLE bubble; no input/output overlap).
- in_a, in_b, in_cin are ignored outside IDLE. Changing them mid-RUN has no effect on the result.
- out_ready is ignored outside DONE.
- Arithmetic wrap: {out_cout, out_sum} equals in_a + in_b + in_cin exactly (N+1 bits). Unsigned overflow appears only as out_cout=1.
- CHUNKS=1 is legal: RUN lasts one cycle.
- idx width is clog2(CHUNKS), minimum 1 bit.
- Reset asserted mid-RUN or in DONE:
  - Immediately returns everything to reset values.
  - The in-flight result is discarded; no out_valid pulse.

Optional Feature:
- Macro: CHUNKED_ADDER_OVF_EN.
- Defined:
  - Extra output port out_ovf, 1 bit, registered alongside out_cout.
  - out_ovf = carry into the top slice's MSB XOR carry out of the top slice, i.e. two's-complement signed overflow.
  - Reset value 0; held stable in DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=4, CHUNKS=4):
- Carry ripple: A=16'hFFFF, B=16'h0001, cin=0, out_ready=1 -> out_valid exactly 4 edges after accept; out_sum=16'h0000, out_cout=1; in_ready low until DONE->IDLE.
- Carry-in only: A=16'h0000, B=16'h0000, cin=1 -> out_sum=16'h0001, out_cout=0. Also A=16'h1234, B=16'h4321, cin=0 -> 16'h5555, cout 0.
- Backpressure: A=16'h00F0, B=16'h0010, out_ready=0 for 5 cycles -> out_valid stays 1 with out_sum=16'h0100 stable throughout; a new in_valid is not accepted; release out_ready -> IDLE next edge.
- Mid-op stability: change in_a/in_b to 16'hAAAA during RUN -> result still matches the latched operands.
- Reset mid-RUN: drop rst_n after 2 RUN edges -> out_sum=0, out_valid=0, in_ready=1. The next request 16'h0003+16'h0004 -> 16'h0007.
- Overflow (macro defined): A=16'h7FFF, B=16'h0001 -> out_sum=16'h8000, out_cout=0, out_ovf=1. Same test with 16'h8000+16'h8000 -> out_sum=0, out_cout=1, out_ovf=1.
